// File: rtl/mac_pkg.sv
// Shared types and lane-geometry helpers for the MAC operand packer.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FILL,
    DRAIN
  } pack_state_t;

  // Non-power-of-two lane counts fall back to a single lane.
  function automatic int lanes_f(input int config_aw);
    int l;
    l = config_aw + 1;
    if ((l & (l - 1)) != 0) l = 1;
    return l;
  endfunction

  function automatic int lane_width_f(input int width, input int l);
    return width / l;
  endfunction

endpackage

// File: rtl/mac_operand_packer_if.sv
// Operand-pair stream into the packer: valid/ready with last marker.
interface mac_operand_packer_if #(
  parameter int W_WIDTH = 8,
  parameter int A_WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [W_WIDTH-1:0] in_w;
  logic [A_WIDTH-1:0] in_a;
  logic               in_last;

  modport master (
    output in_valid, in_w, in_a, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_w, in_a, in_last,
    output in_ready
  );
endinterface

// File: rtl/mac_lane_aligner.sv
// Masks an operand to its precision and MSB-aligns it in an LW-bit lane.
module mac_lane_aligner #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]       operand,
  input  logic [$clog2(WIDTH):0] prec,
  input  logic [$clog2(WIDTH):0] lw,
  output logic [WIDTH-1:0]       lane
);
  localparam int PW = $clog2(WIDTH) + 1;

  logic [PW-1:0]    p;
  logic [WIDTH-1:0] mask;

  always_comb begin
    p = prec;
    if (prec == '0 || prec > lw) p = lw;
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (PW'(i) < p);
    end
    lane = (operand & mask) << (lw - p);
  end

endmodule

// File: rtl/mac_operand_packer.sv
// Packs (w,a) pairs into MAC subword lanes and frames each run.
// Optional guard-bit overflow check: MAC_PACK_GUARD_CHECK_EN.
module mac_operand_packer
  import mac_pkg::*;
#(
  parameter int W_WIDTH         = 8,
  parameter int A_WIDTH         = 8,
  parameter int PLUS_WIDTH      = 4,
  parameter int CONFIG_AW_WIDTH = 1,
  parameter int MAC_LATENCY     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CONFIG_AW_WIDTH-1:0] config_aw,
  input  logic [$clog2(W_WIDTH):0]   w_prec,
  input  logic [$clog2(A_WIDTH):0]   a_prec,
  mac_operand_packer_if.slave        in_if,
  output logic [W_WIDTH-1:0]         w,
  output logic [A_WIDTH-1:0]         a,
  output logic                       accu_rst,
  output logic [CONFIG_AW_WIDTH-1:0] config_aw_o,
  output logic                       acc_done,
  output logic                       guard_ovf
);
  localparam int CAW = CONFIG_AW_WIDTH;
  localparam int WPW = $clog2(W_WIDTH) + 1;
  localparam int APW = $clog2(A_WIDTH) + 1;
  localparam int DW  = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  pack_state_t        state_q, state_d;
  logic [CAW-1:0]     cfg_q, cfg_d;
  logic [CAW-1:0]     lane_q, lane_d;
  logic [WPW-1:0]     w_prec_q, w_prec_d;
  logic [APW-1:0]     a_prec_q, a_prec_d;
  logic [W_WIDTH-1:0] pack_w_q, pack_w_d;
  logic [A_WIDTH-1:0] pack_a_q, pack_a_d;
  logic [W_WIDTH-1:0] w_q, w_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic               accu_rst_q, accu_rst_d;
  logic               in_ready_q, in_ready_d;
  logic               acc_done_q, acc_done_d;
  logic [DW-1:0]      drain_q, drain_d;

  int                 lanes;
  int                 sh_w;
  int                 sh_a;
  logic [WPW-1:0]     lw_w;
  logic [APW-1:0]     lw_a;
  logic [W_WIDTH-1:0] al_w, word_w;
  logic [A_WIDTH-1:0] al_a, word_a;
  logic               accept;
  logic               emit;

  assign lanes = lanes_f(int'(cfg_q));
  assign lw_w  = WPW'(lane_width_f(W_WIDTH, lanes));
  assign lw_a  = APW'(lane_width_f(A_WIDTH, lanes));

  mac_lane_aligner #(.WIDTH(W_WIDTH)) u_w_align (
    .operand (in_if.in_w),
    .prec    (w_prec_q),
    .lw      (lw_w),
    .lane    (al_w)
  );

  mac_lane_aligner #(.WIDTH(A_WIDTH)) u_a_align (
    .operand (in_if.in_a),
    .prec    (a_prec_q),
    .lw      (lw_a),
    .lane    (al_a)
  );

  assign sh_w   = int'(lane_q) * int'(lw_w);
  assign sh_a   = int'(lane_q) * int'(lw_a);
  assign word_w = pack_w_q | (al_w << sh_w);
  assign word_a = pack_a_q | (al_a << sh_a);
  assign accept = in_if.in_valid & in_ready_q;
  assign emit   = accept &
                  ((int'(lane_q) == lanes - 1) | in_if.in_last);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    lane_d     = lane_q;
    w_prec_d   = w_prec_q;
    a_prec_d   = a_prec_q;
    pack_w_d   = pack_w_q;
    pack_a_d   = pack_a_q;
    drain_d    = drain_q;
    w_d        = '0;
    a_d        = '0;
    accu_rst_d = 1'b0;
    acc_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          state_d    = CLEAR;
          accu_rst_d = 1'b1;
        end
      end
      CLEAR: begin
        cfg_d    = config_aw;
        w_prec_d = w_prec;
        a_prec_d = a_prec;
        lane_d   = '0;
        pack_w_d = '0;
        pack_a_d = '0;
        state_d  = FILL;
      end
      FILL: begin
        if (emit) begin
          w_d      = word_w;
          a_d      = word_a;
          lane_d   = '0;
          pack_w_d = '0;
          pack_a_d = '0;
          if (in_if.in_last) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else if (accept) begin
          lane_d   = lane_q + 1'b1;
          pack_w_d = word_w;
          pack_a_d = word_a;
        end
      end
      DRAIN: begin
        // acc_done lands MAC_LATENCY cycles after the last word.
        if (drain_q == DW'(MAC_LATENCY - 1)) begin
          acc_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      lane_q     <= '0;
      w_prec_q   <= '0;
      a_prec_q   <= '0;
      pack_w_q   <= '0;
      pack_a_q   <= '0;
      drain_q    <= '0;
      w_q        <= '0;
      a_q        <= '0;
      accu_rst_q <= 1'b1;
      in_ready_q <= 1'b0;
      acc_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      lane_q     <= lane_d;
      w_prec_q   <= w_prec_d;
      a_prec_q   <= a_prec_d;
      pack_w_q   <= pack_w_d;
      pack_a_q   <= pack_a_d;
      drain_q    <= drain_d;
      w_q        <= w_d;
      a_q        <= a_d;
      accu_rst_q <= accu_rst_d;
      in_ready_q <= in_ready_d;
      acc_done_q <= acc_done_d;
    end
  end

`ifdef MAC_PACK_GUARD_CHECK_EN
  logic [PLUS_WIDTH:0] gcnt_q, gcnt_d;
  logic                govf_q, govf_d;

  always_comb begin
    gcnt_d = gcnt_q;
    govf_d = govf_q;
    if (state_q == CLEAR) begin
      gcnt_d = '0;
      govf_d = 1'b0;
    end else if (emit) begin
      if (int'(gcnt_q) >= (1 << PLUS_WIDTH)) govf_d = 1'b1;
      else gcnt_d = gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= '0;
      govf_q <= 1'b0;
    end else begin
      gcnt_q <= gcnt_d;
      govf_q <= govf_d;
    end
  end

  assign guard_ovf = govf_q;
`else
  assign guard_ovf = 1'b0;
`endif

  assign w              = w_q;
  assign a              = a_q;
  assign accu_rst       = accu_rst_q;
  assign config_aw_o    = cfg_q;
  assign acc_done       = acc_done_q;
  assign in_if.in_ready = in_ready_q;

endmodule
